// File: rtl/fpu_muldiv_iter.sv
`timescale 1ns/1ps
// fpu_muldiv_iter
//   Iterative IEEE-754 multiply/divide unit: one operation in flight, fixed
//   latency (accept edge k -> out_valid after edge k+MAN_W+5), RNE rounding,
//   flush-to-zero for subnormal inputs and results.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   in_valid/ready  request handshake; a, b, op latched on acceptance
//   op              00=MUL, 01=DIV, 1x=reserved (returns qNaN + NV)
//   out_valid/ready result handshake; result, flags held until accepted
//   flags           {NV,DZ,OF,UF,NX}
//   busy            high whenever the FSM is not IDLE
module fpu_muldiv_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FTZ   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [1:0]             op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             flags,
    output logic                   busy
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;         // mantissa with hidden bit
    localparam int QW = MAN_W + 3;         // quotient bits / iteration count
    localparam int CW = $clog2(QW + 1);
    localparam int EW = EXP_W + 2;         // working exponent, two's complement
    localparam int BIAS_I = 2**(EXP_W-1) - 1;
    localparam int EMAX_I = 2**EXP_W - 1;
    localparam logic [EW-1:0] BIAS = BIAS_I[EW-1:0];
    localparam logic [EW-1:0] EMAX = EMAX_I[EW-1:0];
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_t;
    state_t st;

    logic [W-1:0]    a_r, b_r;
    logic [1:0]      op_r;
    logic            sign;
    logic [EW-1:0]   exp_r;
    logic [M-1:0]    ma, mb, mq;
    logic [2*M-1:0]  prod;
    logic [M:0]      rem;
    logic [QW-1:0]   quo;
    logic [CW-1:0]   cnt;
    logic            spec;
    logic [W-1:0]    spec_res;
    logic [4:0]      spec_fl;

    // ---------------- operand classification / special cases ----------------
    logic               sa, sb, sgn;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               za, zb, ia, ib, na, nb, sn;
    logic               sp;
    logic [W-1:0]       sp_res;
    logic [4:0]         sp_fl;
    logic [EW-1:0]      exp_n;

    always_comb begin
        sa  = a_r[W-1];
        sb  = b_r[W-1];
        ea  = a_r[W-2:MAN_W];
        eb  = b_r[W-2:MAN_W];
        fa  = a_r[MAN_W-1:0];
        fb  = b_r[MAN_W-1:0];
        sgn = sa ^ sb;
        // With FTZ every exponent-0 encoding is zero; FTZ=0 is not supported
        // in this generation (subnormals would then enter without renormalising).
        za  = (ea == '0) && ((FTZ != 0) || (fa == '0));
        zb  = (eb == '0) && ((FTZ != 0) || (fb == '0));
        ia  = (&ea) && (fa == '0);
        ib  = (&eb) && (fb == '0);
        na  = (&ea) && (fa != '0);
        nb  = (&eb) && (fb != '0);
        sn  = (na && !fa[MAN_W-1]) || (nb && !fb[MAN_W-1]);

        if (op_r[0])
            exp_n = {2'b00, ea} - {2'b00, eb} + BIAS;
        else
            exp_n = {2'b00, ea} + {2'b00, eb} - BIAS;

        sp     = 1'b1;
        sp_res = QNAN;
        sp_fl  = 5'b00000;
        if (op_r[1]) begin
            sp_fl = 5'b10000;
        end else if (na || nb) begin
            sp_fl = {sn, 4'b0000};
        end else if (!op_r[0]) begin
            if ((za && ib) || (ia && zb))  sp_fl  = 5'b10000;
            else if (ia || ib)             sp_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (za || zb)             sp_res = {sgn, {(W-1){1'b0}}};
            else                           sp     = 1'b0;
        end else begin
            if ((za && zb) || (ia && ib))  sp_fl  = 5'b10000;
            else if (ia)                   sp_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (zb) begin
                sp_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                sp_fl  = 5'b01000;
            end
            else if (ib || za)             sp_res = {sgn, {(W-1){1'b0}}};
            else                           sp     = 1'b0;
        end
    end

    // ---------------- normalise + round ----------------
    logic               is_mul, hi, g, s, rup;
    logic [M-1:0]       mant;
    logic [M:0]         mr;
    logic [MAN_W-1:0]   frac2;
    logic [EW-1:0]      e1, e2;
    logic [W-1:0]       rnd_res;
    logic [4:0]         rnd_fl;

    always_comb begin
        is_mul = !op_r[0];
        if (is_mul) begin
            // product of two [1,2) values lies in [1,4)
            hi   = prod[2*M-1];
            mant = hi ? prod[2*M-1:M] : prod[2*M-2:M-1];
            g    = hi ? prod[M-1]     : prod[M-2];
            s    = hi ? (|prod[M-2:0]) : (|prod[M-3:0]);
            e1   = hi ? exp_r + EW'(1) : exp_r;
        end else begin
            // quotient lies in (0.5,2); the remainder carries all lower bits
            hi   = quo[QW-1];
            mant = hi ? quo[QW-1:2] : quo[QW-2:1];
            g    = hi ? quo[1] : quo[0];
            s    = hi ? (quo[0] || (rem != '0)) : (rem != '0);
            e1   = hi ? exp_r : exp_r - EW'(1);
        end
        rup   = g && (s || mant[0]);
        mr    = {1'b0, mant} + {{M{1'b0}}, rup};
        // carry-out means mantissa rounded up to 2.0
        frac2 = mr[M] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        e2    = mr[M] ? e1 + EW'(1) : e1;

        if (spec) begin
            rnd_res = spec_res;
            rnd_fl  = spec_fl;
        end else if (!e2[EW-1] && (e2 >= EMAX)) begin
            rnd_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_fl  = 5'b00101;
        end else if (e2[EW-1] || (e2 == '0)) begin
            rnd_res = {sign, {(W-1){1'b0}}};
            rnd_fl  = 5'b00011;
        end else begin
            rnd_res = {sign, e2[EXP_W-1:0], frac2};
            rnd_fl  = {4'b0000, g || s};
        end
    end

    // ---------------- control FSM + datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            flags     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            sign      <= 1'b0;
            exp_r     <= '0;
            ma        <= '0;
            mb        <= '0;
            mq        <= '0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            spec      <= 1'b0;
            spec_res  <= '0;
            spec_fl   <= '0;
        end else begin
            unique case (st)
                IDLE: if (in_valid) begin
                    a_r      <= a;
                    b_r      <= b;
                    op_r     <= op;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    st       <= UNPACK;
                end
                UNPACK: begin
                    sign     <= sgn;
                    exp_r    <= exp_n;
                    ma       <= {1'b1, fa};
                    mb       <= {1'b1, fb};
                    mq       <= {1'b1, fb};
                    prod     <= '0;
                    rem      <= {2'b01, fa};
                    quo      <= '0;
                    cnt      <= CW'(QW - 1);
                    spec     <= sp;
                    spec_res <= sp_res;
                    spec_fl  <= sp_fl;
                    st       <= ITER;
                end
                ITER: begin
                    // multiply consumes M multiplier bits MSB-first in the
                    // first M cycles; the last two cycles only pad latency
                    if (cnt >= CW'(2)) begin
                        prod <= (prod << 1) + (mq[M-1] ? {{M{1'b0}}, ma} : '0);
                        mq   <= mq << 1;
                    end
                    if (rem >= {1'b0, mb}) begin
                        rem <= (rem - {1'b0, mb}) << 1;
                        quo <= {quo[QW-2:0], 1'b1};
                    end else begin
                        rem <= rem << 1;
                        quo <= {quo[QW-2:0], 1'b0};
                    end
                    if (cnt == '0) st  <= ROUND;
                    else           cnt <= cnt - CW'(1);
                end
                ROUND: begin
                    result    <= rnd_res;
                    flags     <= rnd_fl;
                    out_valid <= 1'b1;
                    st        <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    st        <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
